mult_seq: RTL and testbench

//  Iterative shift-add multiplier for the CPU execute stage; implements MULT (signed) and MULTU (unsigned).

---
 rtl/mult_seq.sv | 134 +++++++++++++
 tb/tb_mult_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq : iterative shift-add multiplier for the execute stage (MULT/MULTU)
//
// Retires BITS_PER_CYCLE multiplier bits per clock through a single
// partial-product adder. The operands are reduced to magnitudes at acceptance.
// The sign is reapplied once, when the result is written to z.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   start   operation request, sampled only while idle
//   sign    1 = signed (MULT), 0 = unsigned (MULTU), sampled with start
//   cancel  synchronous abort of an in-flight operation
//   a, b    multiplicand / multiplier, sampled with start
//   busy    high while the partial products are being accumulated
//   done    one-cycle pulse, z valid
//   z       2*WIDTH product, held until the next completed operation
// ---------------------------------------------------------------------------
module mult_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sign,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;  // multiplicand magnitude, pre-shifted to the current chunk weight
  logic [WIDTH-1:0]     mb;     // remaining multiplier bits, consumed from the LSB end
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;

  // Magnitude of an operand. The most negative value maps to 2^(W-1), which
  // still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             s);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (s && v[WIDTH-1]) ? WIDTH'(-sv) : v;
  endfunction

  // mcand * chunk, built from shifted copies so only BITS_PER_CYCLE adds are needed.
  function automatic logic [2*WIDTH-1:0] partial(input logic [2*WIDTH-1:0]       m,
                                                 input logic [BITS_PER_CYCLE-1:0] c);
    logic [2*WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (c[i]) p = p + (m << i);
    end
    return p;
  endfunction

  // Restores the product sign as a 2*WIDTH two's complement value.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic               n);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return n ? (2*WIDTH)'(-sv) : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cnt   <= '0;
      mcand <= '0;
      mb    <= '0;
      acc   <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // cancel in the same cycle suppresses acceptance
          if (start && !cancel) begin
            mcand <= {{WIDTH{1'b0}}, magnitude(a, sign)};
            mb    <= magnitude(b, sign);
            neg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc + partial(mcand, mb[BITS_PER_CYCLE-1:0]);
            mcand <= mcand << BITS_PER_CYCLE;
            mb    <= mb >> BITS_PER_CYCLE;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              state <= FINISH;
              busy  <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          // z is only touched here, so it never exposes a partial sum
          if (!cancel) begin
            z    <= apply_sign(acc, neg);
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start_x, sign, cancel;
  logic [31:0] a, b;
  logic [3:0]  busy, done;
  logic [63:0] z0, z1, z2;
  logic [15:0] z3;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // u0 is the main instance; u1..u3 run only when start_x is pulsed
  mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy[0]), .done(done[0]), .z(z0));
  mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(2)) u1 (
    .clk(clk), .reset(reset), .start(start_x), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy[1]), .done(done[1]), .z(z1));
  mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u2 (
    .clk(clk), .reset(reset), .start(start_x), .sign(sign), .cancel(cancel),
    .a(a), .b(b), .busy(busy[2]), .done(done[2]), .z(z2));
  mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) u3 (
    .clk(clk), .reset(reset), .start(start_x), .sign(sign), .cancel(cancel),
    .a(a[7:0]), .b(b[7:0]), .busy(busy[3]), .done(done[3]), .z(z3));

  int          lat_exp [4] = '{33, 17, 9, 5};
  int          lat     [4];
  int          ndone   [4];
  logic [63:0] zc      [4];
  int          nbusy;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] ref8(input bit s, input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    return {8'b0, x} * {8'b0, y};
  endfunction

  function automatic logic [63:0] zsel(input int i);
    case (i)
      0:       return z0;
      1:       return z1;
      2:       return z2;
      default: return {48'b0, z3};
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge right after the accepting edge; operands are then scrambled.
  task automatic launch(input bit s, input logic [31:0] x, input logic [31:0] y, input bit all);
    @(negedge clk);
    sign = s; a = x; b = y; start = 1'b1; start_x = all;
    cycle();
    start = 1'b0; start_x = 1'b0;
    a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int maxk);
    nbusy = busy[0] ? 1 : 0;
    for (int i = 0; i < 4; i++) begin lat[i] = 0; ndone[i] = 0; zc[i] = '0; end
    for (int k = 1; k <= maxk; k++) begin
      cycle();
      if (busy[0]) nbusy++;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          ndone[i]++;
          if (lat[i] == 0) begin lat[i] = k; zc[i] = zsel(i); end
        end
      end
    end
  endtask

  task automatic do_all(input bit s, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] e;
    launch(s, x, y, 1'b1);
    collect(36);
    for (int i = 0; i < 4; i++) begin
      e = (i < 3) ? ref32(s, x, y) : {48'b0, ref8(s, x[7:0], y[7:0])};
      chk($sformatf("%s u%0d latency", tag, i), 64'(lat[i]), 64'(lat_exp[i]));
      chk($sformatf("%s u%0d done count", tag, i), 64'(ndone[i]), 64'd1);
      chk($sformatf("%s u%0d z", tag, i), zc[i], e);
    end
    chk($sformatf("%s busy cycles", tag), 64'(nbusy), 64'd32);
  endtask

  initial begin
    int          k;
    bit          s;
    logic [31:0] x, y;
    logic [31:0] corner [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};

    reset = 1'b0; start = 1'b0; start_x = 1'b0; sign = 1'b0; cancel = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {60'b0, busy}, 64'd0);
    chk("reset done", {60'b0, done}, 64'd0);
    chk("reset z0", z0, 64'd0);
    chk("reset z3", {48'b0, z3}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Unsigned maximum operands
    do_all(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
    chk("multu max const", zc[0], 64'hFFFFFFFE00000001);

    // Signed corner cases
    do_all(1'b1, 32'hFFFFFFFD, 32'd5, "mult -3*5");
    chk("mult -3*5 const", zc[0], 64'hFFFFFFFFFFFFFFF1);
    do_all(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mult -1*-1");
    chk("mult -1*-1 const", zc[0], 64'd1);
    do_all(1'b1, 32'h80000000, 32'h80000000, "mult min*min");
    chk("mult min*min const", zc[0], 64'h4000000000000000);

    // Start while busy is ignored; start in the done cycle is accepted
    launch(1'b0, 32'd7, 32'd6, 1'b0);
    repeat (3) cycle();
    start = 1'b1; a = 32'd2; b = 32'd2;
    cycle();
    start = 1'b0;
    k = 4;
    while (!done[0] && k < 40) begin cycle(); k++; end
    chk("restart ignored latency", 64'(k), 64'd33);
    chk("restart ignored z", z0, 64'd42);
    start = 1'b1; sign = 1'b0; a = 32'd3; b = 32'd5;
    cycle();
    start = 1'b0;
    collect(36);
    chk("back-to-back latency", 64'(lat[0]), 64'd33);
    chk("back-to-back done count", 64'(ndone[0]), 64'd1);
    chk("back-to-back z", zc[0], 64'd15);

    // Cancel in CALC cycle 10
    launch(1'b0, 32'd3, 32'd3, 1'b0);
    repeat (9) cycle();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
    chk("cancel busy", {63'b0, busy[0]}, 64'd0);
    collect(40);
    chk("cancel no done", 64'(ndone[0]), 64'd0);
    chk("cancel z held", z0, 64'd15);
    launch(1'b0, 32'd0, 32'd0, 1'b0);
    collect(36);
    chk("zero op latency", 64'(lat[0]), 64'd33);
    chk("zero op z", zc[0], 64'd0);
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; sign = 1'b0; a = 32'd9; b = 32'd9;
    cycle();
    start = 1'b0; cancel = 1'b0;
    chk("cancel+start busy", {63'b0, busy[0]}, 64'd0);
    collect(40);
    chk("cancel+start no done", 64'(ndone[0]), 64'd0);
    chk("cancel+start z", z0, 64'd0);

    // Asynchronous reset mid-operation
    launch(1'b0, 32'd5, 32'd5, 1'b0);
    collect(36);
    chk("pre-reset z", zc[0], 64'd25);
    launch(1'b0, 32'h1234, 32'h5678, 1'b0);
    repeat (4) cycle();
    chk("mid-op busy", {63'b0, busy[0]}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async reset busy", {63'b0, busy[0]}, 64'd0);
    chk("async reset done", {63'b0, done[0]}, 64'd0);
    chk("async reset z", z0, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    launch(1'b0, 32'h10000, 32'h10000, 1'b0);
    collect(36);
    chk("post-reset latency", 64'(lat[0]), 64'd33);
    chk("post-reset done count", 64'(ndone[0]), 64'd1);
    chk("post-reset z", zc[0], 64'h100000000);

    // Randomized sweep over all instances
    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      do_all(s, x, y, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
